store_sequencer: RTL and testbench

Multi-cycle controller that performs word, halfword and byte stores against the word-wide data memory of the multicycle CPU. Word stores are written directly. Sub-word stores run a read-modify-write sequence: read the containing word, merge the new byte or halfword into the correct lane, then write the word back. The block sits between the control unit, which issues a store request, and the memory port. It also detects misaligned and reserved requests.

---
 rtl/store_pkg.sv | 31 +++
 rtl/store_merge.sv | 37 +++
 rtl/store_sequencer.sv | 124 ++++++++++++
 tb/tb_store_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the sub-word store path: op encodings, sequencer states
// and the alignment check.
package store_pkg;

    typedef enum logic [1:0] {
        OP_SW   = 2'b00,
        OP_SH   = 2'b01,
        OP_SB   = 2'b10,
        OP_RSVD = 2'b11
    } store_op_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } store_state_t;

    // Reserved op is not a misalignment; the caller flags it separately.
    function automatic logic is_misaligned(input store_op_t op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_SW:   bad = (addr_lo != 2'b00);
            OP_SH:   bad = addr_lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: drops a byte or halfword from b_data into the
// word previously read from memory.
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] mdr,
    input  logic [31:0] b_data,
    input  store_op_t   op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    // Lane replacement keyed by op and the low address bits.
    always_comb begin
        merged = mdr;
        case (op)
            OP_SW: merged = b_data;
            OP_SH: begin
                if (addr_lo[1]) begin
                    merged[31:16] = b_data[15:0];
                end else begin
                    merged[15:0] = b_data[15:0];
                end
            end
            OP_SB: begin
                case (addr_lo)
                    2'b00:   merged[7:0]   = b_data[7:0];
                    2'b01:   merged[15:8]  = b_data[7:0];
                    2'b10:   merged[23:16] = b_data[7:0];
                    default: merged[31:24] = b_data[7:0];
                endcase
            end
            default: merged = mdr;
        endcase
    end

endmodule

// File: rtl/store_sequencer.sv
// Multi-cycle store controller: direct word writes, read-modify-write for
// halfword/byte stores, early completion with error on bad requests.
module store_sequencer
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    store_state_t      state_q;
    store_op_t         op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] mdr_q;
    logic              rd_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    store_op_t         op_in_s;
    logic              req_err_s;
    logic [31:0]       merged_s;

    assign op_in_s   = store_op_t'(op);
    assign req_err_s = (op_in_s == OP_RSVD) || is_misaligned(op_in_s, addr[1:0]);

    store_merge u_merge (
        .mdr     (mdr_q),
        .b_data  (b_q),
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .merged  (merged_s)
    );

    // Sequencer FSM; strobes and status are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_SW;
            addr_q  <= '0;
            b_q     <= '0;
            mdr_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // DONE accepts a new request exactly like IDLE for back-to-back stores.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q   <= op_in_s;
                        addr_q <= addr;
                        b_q    <= b_data;
                        if (req_err_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (op_in_s == OP_SW) begin
                            state_q <= S_WRITE;
                            wr_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            rd_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_READ: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    mdr_q   <= mem_rdata;
                    state_q <= S_WRITE;
                    wr_q    <= 1'b1;
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = (state_q == S_WRITE) ? merged_s : '0;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: expected writes and completions are
// queued at issue time and popped by monitors when the DUT produces them.
module tb_store_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] b_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    logic [31:0] mem_val;
    wr_exp_t     wq[$];
    logic        dq[$];
    int          n_vec;
    int          n_miss;

    store_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .b_data    (b_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns mem_val the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] o, input logic [31:0] m,
                                               input logic [31:0] b, input logic [1:0] a);
        logic [31:0] mask;
        int          sh;
        if (o == 2'b00) return b;
        if (o == 2'b01) begin
            sh = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (m & ~mask) | ((b & 32'h0000_FFFF) << sh);
        end
        sh = 8 * int'(a);
        mask = 32'h0000_00FF << sh;
        return (m & ~mask) | ((b & 32'h0000_00FF) << sh);
    endfunction

    function automatic logic model_err(input logic [1:0] o, input logic [1:0] a);
        return (o == 2'b11) || (o == 2'b00 && a != 2'b00) || (o == 2'b01 && a[0]);
    endfunction

    // Write monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_exp_t e;
        check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
        if (error) check("err_wo_done", {31'd0, done}, 32'd1);
        if (mem_wr) begin
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end else begin
                check("unexp_wr", {31'd0, mem_wr}, 32'd0);
            end
        end
        if (done) begin
            if (dq.size() > 0) check("done_err", {31'd0, error}, {31'd0, dq.pop_front()});
            else               check("unexp_done", {31'd0, done}, 32'd0);
        end
    end

    // One store with cycle-exact strobe checks; options for intruding start,
    // chaining the next request into DONE, pre-issued start and reset abort.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m, input bit intrude, input bit chain,
                         input bit preissued, input bit abort,
                         input logic [1:0] no, input logic [31:0] na, input logic [31:0] nb);
        logic    err;
        bit      sw;
        int      lat;
        wr_exp_t e;
        err = model_err(o, a[1:0]);
        sw  = (o == 2'b00);
        lat = err ? 1 : (sw ? 2 : 4);
        mem_val = m;
        if (!err) begin
            e.addr = {a[31:2], 2'b00};
            e.data = model_word(o, m, b, a[1:0]);
            wq.push_back(e);
        end
        if (!abort) dq.push_back(err);
        if (!preissued) begin
            @(negedge clk);
            start = 1'b1; op = o; addr = a; b_data = b;
        end
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = intrude; op = 2'b00; addr = ~a & 32'hFFFF_FFFC; b_data = ~b;
            end else begin
                start = 1'b0;
            end
            check("mem_rd",   {31'd0, mem_rd}, {31'd0, (!err && !sw && k == 1)});
            check("mem_wr_t", {31'd0, mem_wr}, {31'd0, (!err && (sw ? k == 1 : k == 3))});
            check("done_t",   {31'd0, done},   {31'd0, (k == lat)});
            check("busy",     {31'd0, busy},   {31'd0, (k < lat)});
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (abort && k == 3) begin
                #2 reset = 1'b1;
                #1;
                check("abort_wr",   {31'd0, mem_wr}, 32'd0);
                check("abort_outs", {mem_rd, busy, done, error}, 4'd0);
                check("abort_addr", mem_addr, 32'd0);
                check("abort_wd",   mem_wdata, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (chain && k == lat) begin
                start = 1'b1; op = no; addr = na; b_data = nb;
            end
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        n_vec = 0; n_miss = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; addr = 32'd0; b_data = 32'd0;
        mem_val = 32'd0; mem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_outs", {mem_rd, mem_wr, busy, done, error}, 5'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wd",   mem_wdata, 32'd0);
        reset = 1'b0;

        do_op(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b10, 32'h0000_0021, 32'h0000_00AB, 32'h1122_3344, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b01, 32'h0000_0042, 32'h0000_CAFE, 32'h1122_3344, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b01, 32'h0000_0043, 32'h0000_1234, 32'h0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b11, 32'h0000_0000, 32'h0000_5678, 32'h0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b00, 32'h0000_0002, 32'h0BAD_F00D, 32'h0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b10, 32'h0000_0023, 32'h1234_56EF, 32'hA5A5_A5A5, 1, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b01, 32'h0000_0040, 32'hFFFF_BEEF, 32'h0102_0304, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b00, 32'h0000_0100, 32'h1357_9BDF, 32'h0, 0, 1, 0, 0, 2'b10, 32'h0000_0105, 32'h0000_0077);
        do_op(2'b10, 32'h0000_0105, 32'h0000_0077, 32'hCCDD_EEFF, 0, 0, 1, 0, 2'b00, 32'h0, 32'h0);
        do_op(2'b10, 32'h0000_0031, 32'h0000_0099, 32'h5566_7788, 0, 0, 0, 1, 2'b00, 32'h0, 32'h0);
        do_op(2'b10, 32'h0000_0020, 32'h0000_0011, 32'hFFFF_FFFF, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            do_op(ro, ra, $urandom, $urandom, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        end
        repeat (4) @(negedge clk);
        check("wq_left", 32'(wq.size()), 32'd0);
        check("dq_left", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
